display_ctrl: RTL and testbench
===============================

// Module: display_ctrl
// PURPOSE
//  Sequencing controller for the 4-digit seven-segment display and sign LED.
//  - Accepts signed 14-bit values written by the soft processor (OUT instruction).
//  - Converts |value| to 4 BCD digits serially (shift-add-3, one bit per clock).
//  - Holds the last displayed value stable until a new conversion completes; the
//    digit outputs feed the per-digit seven-segment decoders.
//  - Buffers one pending write so the processor never stalls on the display.
// PARAMETERS
//  WIDTH   14  input width incl. sign; also the number of conversion iterations
//  DIGITS  4   BCD digits produced; 10^DIGITS must exceed 2^(WIDTH-1)
// PORTS
//  clk        in   1           single system clock, rising edge
//  rst_n      in   1           asynchronous, active-low reset
//  wr_en      in   1           write strobe from processor, one value per high cycle
//  wr_data    in   WIDTH       signed two's-complement value to display
//  busy       out  1           conversion in progress (SHIFT or UPDATE)
//  done       out  1           one-cycle pulse when new digits/sig are valid
//  sig        out  1           sign LED, 1 = negative
//  dig        out  4*DIGITS    BCD digits, dig[3:0] = units ... dig[15:12] = thousands
//  blank      out  DIGITS      1 = digit is a leading zero and is blanked
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE, busy=0, done=0, sig=0, dig=0,
//   blank={DIGITS-1{1},1'b0}, pending register empty, shift/count regs cleared.
//  States: IDLE -> SHIFT -> UPDATE -> (IDLE | SHIFT).
//  - IDLE: if wr_en, load mag=|wr_data| (WIDTH-bit unsigned; -8192 -> 8192), neg,
//    BCD accumulator=0, cnt=0; go SHIFT. Else if pending valid, load from pending.
//  - SHIFT: per clock, add 3 to each BCD nibble >=5, then shift {bcd,mag} left
//    by 1; cnt++. After WIDTH iterations go UPDATE.
//  - UPDATE: dig<=bcd, sig<=neg & (mag_in!=0), blank recomputed, done=1 for this
//    one cycle. Next: if wr_en this cycle, start it (pending discarded); else if
//    pending valid, start pending and clear it; else IDLE.
//  Latency: wr_en sampled in IDLE at edge E0 -> done high and outputs updated
//   after edge E0+WIDTH+1 (15 clocks at default). Throughput 1 value / WIDTH+1 clocks.
//  busy is 0 only in IDLE; wr_en is legal in every state (no back-pressure).
//  Pending buffer: depth 1, last-write-wins; wr_en during SHIFT overwrites it.
//  Outputs dig/sig/blank change only in UPDATE; never show partial results.
//  blank: digit k blanked iff all digits k..DIGITS-1 are 0 and k>0; units never blank.
//  Zero is never shown negative (sig=0 for value 0).
//  Reset mid-conversion: conversion and pending write are discarded; outputs go to
//   reset values immediately; no done pulse is produced.
// STRUCTURE
//  Package display_pkg: state enum (IDLE, SHIFT, UPDATE), WIDTH/DIGITS defaults,
//   localparam CNT_W=$clog2(WIDTH+1), BCD nibble typedef.
//  Sub-module bcd_add3: combinational 4-bit "add 3 if >=5" nibble corrector,
//   instantiated DIGITS times by generate.
//  Everything else (FSM, pending buffer, output regs) lives in display_ctrl.
// TESTING
//  1 Assert rst_n=0 then release -> busy=0, done=0, sig=0, dig=16'h0000, blank=4'b1110.
//  2 wr_en with 1234 in IDLE -> done after 15 clocks, dig=16'h1234, sig=0, blank=0000.
//  3 wr_en with -8192 -> dig=16'h8192, sig=1; wr_en with 8191 -> dig=16'h8191, sig=0.
//  4 write 7, then 42 and 99 while busy -> done shows 0007, next done shows 0099
//    (42 dropped), exactly two done pulses, busy low only after second UPDATE.
//  5 write 0 -> dig=0, blank=1110, sig=0; write -5 -> dig=16'h0005, blank=1110, sig=1;
//    write 40 -> blank=1100.
//  6 write 555, pulse rst_n low at clock 6 of SHIFT -> reset values at once, no done;
//    after release, write 12 -> dig=16'h0012 after 15 clocks.

Source files
------------

// File: rtl/display_pkg.sv
// Shared types and defaults for the seven-segment display controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package display_pkg;

   localparam int DEF_WIDTH  = 14;
   localparam int DEF_DIGITS = 4;
   localparam int CNT_W      = $clog2(DEF_WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      UPDATE
   } state_t;

   typedef logic [3:0] bcd_nib_t;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble nibble corrector: adds 3 when the nibble is 5 or more.
// Latency: combinational.
// Backpressure: none.
module bcd_add3
   import display_pkg::*;
(
   input  bcd_nib_t raw,
   output bcd_nib_t fixed
);

   assign fixed = (raw >= 4'd5) ? raw + 4'd3 : raw;

endmodule

// File: rtl/display_ctrl.sv
// Signed value to BCD digits, sign LED and leading-zero blanking for the display.
// Latency: write sampled at edge E0, done and new outputs after edge E0+WIDTH+1.
// Backpressure: none; one-deep last-write-wins pending slot absorbs writes while busy.
module display_ctrl
   import display_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int DIGITS = DEF_DIGITS
)
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_en,
   input  logic [WIDTH-1:0]      wr_data,
   output logic                  busy,
   output logic                  done,
   output logic                  sig,
   output logic [4*DIGITS-1:0]   dig,
   output logic [DIGITS-1:0]     blank
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam int BW = 4 * DIGITS;

   state_t             state;
   logic [WIDTH-1:0]   mag;
   logic [BW-1:0]      bcd;
   logic [BW-1:0]      corr;
   logic [CW-1:0]      cnt;
   logic               neg;
   logic               pend_vld;
   logic [WIDTH-1:0]   pend_dat;

   logic               start;
   logic [WIDTH-1:0]   start_dat;
   logic [WIDTH-1:0]   start_mag;
   logic [DIGITS-1:0]  blank_nxt;
   logic               upper_zero;

   // One corrector per BCD digit, applied before every shift.
   for (genvar k = 0; k < DIGITS; k++) begin : g_add3
      bcd_add3 u_add3 (
         .raw   (bcd[4*k +: 4]),
         .fixed (corr[4*k +: 4])
      );
   end

   // Pick the next value to convert: a live write beats the pending slot.
   always_comb begin
      start     = (state != SHIFT) && (wr_en || pend_vld);
      start_dat = wr_en ? wr_data : pend_dat;
      // Magnitude as unsigned; the most negative value maps onto itself, which
      // reads correctly as 2^(WIDTH-1) when treated as unsigned.
      start_mag = start_dat[WIDTH-1] ? (~start_dat + {{(WIDTH-1){1'b0}}, 1'b1})
                                     : start_dat;
   end

   // Leading-zero blanking: a digit blanks when it and everything above it is zero.
   always_comb begin
      blank_nxt  = '0;
      upper_zero = 1'b1;
      for (int k = DIGITS - 1; k > 0; k--) begin
         upper_zero   = upper_zero && (bcd[4*k +: 4] == 4'd0);
         blank_nxt[k] = upper_zero;
      end
   end

   assign busy = (state != IDLE);

   // Conversion FSM, pending slot and registered display outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         mag      <= '0;
         bcd      <= '0;
         cnt      <= '0;
         neg      <= 1'b0;
         pend_vld <= 1'b0;
         pend_dat <= '0;
         done     <= 1'b0;
         sig      <= 1'b0;
         dig      <= '0;
         blank    <= {{(DIGITS-1){1'b1}}, 1'b0};
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               state <= start ? SHIFT : IDLE;
            end
            SHIFT: begin
               if (wr_en) begin
                  pend_dat <= wr_data;
                  pend_vld <= 1'b1;
               end
               bcd <= {corr[BW-2:0], mag[WIDTH-1]};
               mag <= {mag[WIDTH-2:0], 1'b0};
               cnt <= cnt + 1'b1;
               if (cnt == CW'(WIDTH - 1)) begin
                  state <= UPDATE;
               end
            end
            UPDATE: begin
               dig   <= bcd;
               // A two's-complement negative is never zero, so neg alone
               // already keeps zero from lighting the sign LED.
               sig   <= neg;
               blank <= blank_nxt;
               done  <= 1'b1;
               state <= start ? SHIFT : IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
         // Load a fresh conversion; a write arriving in UPDATE drops the pending one.
         if (start) begin
            mag      <= start_mag;
            neg      <= start_dat[WIDTH-1];
            bcd      <= '0;
            cnt      <= '0;
            pend_vld <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_display_ctrl.sv
// Directed bench for display_ctrl: reset, conversions, pending slot, blanking, mid-run reset.
// Latency: expects done 15 clocks after a write is sampled.
// Backpressure: writes are issued freely, including while busy.
module tb_display_ctrl;

   logic        clk;
   logic        rst_n;
   logic        wr_en;
   logic [13:0] wr_data;
   logic        busy;
   logic        done;
   logic        sig;
   logic [15:0] dig;
   logic [3:0]  blank;

   int passed   = 0;
   int total    = 0;
   int cyc      = 0;
   int done_cnt = 0;

   display_ctrl dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_en),
      .wr_data (wr_data),
      .busy    (busy),
      .done    (done),
      .sig     (sig),
      .dig     (dig),
      .blank   (blank)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (done) done_cnt <= done_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive one write for a single clock; t returns the index of the sampling edge.
   task automatic wr(input int v, output int t);
      @(negedge clk);
      wr_en   = 1'b1;
      wr_data = v[13:0];
      @(negedge clk);
      wr_en   = 1'b0;
      t       = cyc;
   endtask

   // Step until done is seen (bounded); the latency check fails on timeout.
   task automatic wait_done(input string tag, input int t0, input int exp_lat);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!done && n < 60);
      chk({tag, " latency"}, cyc - t0, exp_lat);
   endtask

   initial begin
      int t;
      int t7;
      int base;
      rst_n   = 1'b1;
      wr_en   = 1'b0;
      wr_data = '0;
      #2 rst_n = 1'b0;

      // 1: reset state, during and after reset
      repeat (3) @(negedge clk);
      chk("rst busy", busy, 0);
      chk("rst done", done, 0);
      chk("rst sig", sig, 0);
      chk("rst dig", dig, 16'h0000);
      chk("rst blank", blank, 4'b1110);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("post-rst busy", busy, 0);
      chk("post-rst dig", dig, 16'h0000);
      chk("post-rst blank", blank, 4'b1110);

      // 2: 1234
      wr(1234, t);
      chk("1234 busy", busy, 1);
      chk("1234 held", dig, 16'h0000);
      wait_done("1234", t, 15);
      chk("1234 dig", dig, 16'h1234);
      chk("1234 sig", sig, 0);
      chk("1234 blank", blank, 4'b0000);
      chk("1234 busy end", busy, 0);
      @(negedge clk);
      chk("1234 done width", done, 0);

      // 3: extremes
      wr(-8192, t);
      wait_done("-8192", t, 15);
      chk("-8192 dig", dig, 16'h8192);
      chk("-8192 sig", sig, 1);
      chk("-8192 blank", blank, 4'b0000);
      wr(8191, t);
      repeat (7) @(negedge clk);
      chk("8191 mid dig", dig, 16'h8192);
      chk("8191 mid sig", sig, 1);
      chk("8191 mid busy", busy, 1);
      wait_done("8191", t, 15);
      chk("8191 dig", dig, 16'h8191);
      chk("8191 sig", sig, 0);

      // 4: pending slot, last write wins
      repeat (2) @(negedge clk);
      base = done_cnt;
      wr(7, t7);
      wr(42, t);
      wr(99, t);
      wait_done("7", t7, 15);
      chk("7 dig", dig, 16'h0007);
      chk("7 blank", blank, 4'b1110);
      chk("7 busy", busy, 1);
      wait_done("99", t7, 30);
      chk("99 dig", dig, 16'h0099);
      chk("99 busy", busy, 0);
      repeat (5) @(negedge clk);
      chk("two dones", done_cnt - base, 2);

      // 5: zero, small negative, blanking
      wr(0, t);
      wait_done("0", t, 15);
      chk("0 dig", dig, 16'h0000);
      chk("0 blank", blank, 4'b1110);
      chk("0 sig", sig, 0);
      wr(-5, t);
      wait_done("-5", t, 15);
      chk("-5 dig", dig, 16'h0005);
      chk("-5 blank", blank, 4'b1110);
      chk("-5 sig", sig, 1);
      wr(40, t);
      wait_done("40", t, 15);
      chk("40 dig", dig, 16'h0040);
      chk("40 blank", blank, 4'b1100);
      chk("40 sig", sig, 0);

      // 6: reset mid-conversion
      wr(555, t);
      repeat (5) @(negedge clk);
      base = done_cnt;
      rst_n = 1'b0;
      #1;
      chk("mid-rst dig", dig, 16'h0000);
      chk("mid-rst blank", blank, 4'b1110);
      chk("mid-rst busy", busy, 0);
      chk("mid-rst sig", sig, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      chk("no done after rst", done_cnt - base, 0);
      chk("idle after rst", busy, 0);
      wr(12, t);
      wait_done("12", t, 15);
      chk("12 dig", dig, 16'h0012);
      chk("12 blank", blank, 4'b1100);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: run did not complete");
      $fatal(1);
   end

endmodule
